// File: rtl/riscv_uart_pkg.sv
// Shared constants for the memory-mapped UART controller: register map,
// STATUS bit positions and the transmit sequencer states.
package riscv_uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_RXDATA = 4'h4;
    localparam logic [3:0] UART_STATUS = 4'h8;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_TX_OVF      = 4;
    localparam int ST_RX_OVR      = 5;
    localparam int ST_TX_ACTIVE   = 6;
    localparam int ST_RX_COUNT    = 8;

    // Cycles spent in WAIT_BUSY without seeing tx_busy before giving up.
    localparam int WAIT_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-facing UART window: TX FIFO feeding a start/busy sequencer, RX FIFO
// for polled reads, and sticky overflow flags reported through STATUS/irq.
module uart_mmio_ctrl
    import riscv_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        UART_sel,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        irq
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCW = $clog2(WAIT_BUSY_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_BUSY_TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

    logic            wr_tx, rd_rx, wr_status;
    logic            tx_pop, tx_full, tx_empty;
    logic [7:0]      tx_head;
    logic [CW-1:0]   tx_count;
    logic            rx_full, rx_empty;
    logic [7:0]      rx_head;
    logic [CW-1:0]   rx_count;

    tx_state_e       state_q;
    logic [WCW-1:0]  wait_cnt_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic            tx_ovf_q, tx_ovf_d;
    logic            rx_ovr_q, rx_ovr_d;
    logic [31:0]     status;
    logic            unused_bits;

    assign wr_tx     = UART_sel && MemWrite && (addr == UART_TXDATA);
    assign rd_rx     = UART_sel && MemRead  && (addr == UART_RXDATA);
    assign wr_status = UART_sel && MemWrite && (addr == UART_STATUS);
    assign tx_pop    = (state_q == START);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (rd_rx),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // A push into a full FIFO only counts as a loss when no pop makes room.
    assign tx_ovf_d = (wr_tx && tx_full && !tx_pop)
                    || (tx_ovf_q && !(wr_status && wdata[ST_TX_OVF]));
    assign rx_ovr_d = (rx_valid && rx_full && !rd_rx)
                    || (rx_ovr_q && !(wr_status && wdata[ST_RX_OVR]));

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovr_q <= rx_ovr_d;
        end
    end

    // tx_start/tx_data are registered on the IDLE->START edge so the pulse
    // coincides exactly with the START cycle, where the head is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!tx_empty && !tx_busy) begin
                        state_q    <= START;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= tx_head;
                    end
                end
                START: begin
                    state_q    <= WAIT_BUSY;
                    wait_cnt_q <= '0;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign irq      = !rx_empty || tx_ovf_q || rx_ovr_q;

    always_comb begin
        status                      = '0;
        status[ST_TX_FULL]          = tx_full;
        status[ST_TX_EMPTY]         = tx_empty;
        status[ST_RX_NONEMPTY]      = !rx_empty;
        status[ST_RX_FULL]          = rx_full;
        status[ST_TX_OVF]           = tx_ovf_q;
        status[ST_RX_OVR]           = rx_ovr_q;
        status[ST_TX_ACTIVE]        = (state_q != IDLE);
        status[ST_RX_COUNT +: 8]    = 8'(rx_count);
    end

    always_comb begin
        rdata = '0;
        case (addr)
            UART_RXDATA: begin
                if (!rx_empty) begin
                    rdata = {23'b0, 1'b1, rx_head};
                end
            end
            UART_STATUS: rdata = status;
            default:     rdata = '0;
        endcase
    end

    assign unused_bits = ^{wdata[31:8], tx_count};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: queue-based reference model of the
// FIFOs and sticky flags, plus a behavioural transmitter with settable busy time.
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        UART_sel = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        irq;

    uart_mmio_ctrl #(.FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .UART_sel (UART_sel),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .irq      (irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model state
    logic [7:0] rx_mq[$];
    logic [7:0] exp_q[$];
    logic       m_tx_ovf = 1'b0;
    logic       m_rx_ovr = 1'b0;
    int         cyc = 0;
    int         pulse_cyc_q[$];
    int         n_checks = 0;
    int         n_pass = 0;

    // transmitter model controls
    int         busy_len = 10;
    bit         hold_busy = 1'b0;
    int         busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_rdata(input logic [3:0] a);
        logic [31:0] r;
        int n;
        int t;
        r = '0;
        n = rx_mq.size();
        t = exp_q.size();
        if (a == 4'h4) begin
            if (n > 0) r = {23'b0, 1'b1, rx_mq[0]};
        end else if (a == 4'h8) begin
            r[0]    = (t == 8);
            r[1]    = (t == 0);
            r[2]    = (n > 0);
            r[3]    = (n == 8);
            r[4]    = m_tx_ovf;
            r[5]    = m_rx_ovr;
            r[15:8] = 8'(n);
        end
        return r;
    endfunction

    function automatic logic exp_irq();
        return (rx_mq.size() > 0) || m_tx_ovf || m_rx_ovr;
    endfunction

    // Applies the current cycle's inputs to the model, as the DUT does at the edge.
    task automatic model_update();
        int  n;
        bit  do_pop, set_r, set_t, clr;
        if (reset) begin
            rx_mq.delete();
            exp_q.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovr = 1'b0;
            return;
        end
        n      = rx_mq.size();
        do_pop = UART_sel && MemRead && (addr == 4'h4) && (n > 0);
        set_r  = 1'b0;
        set_t  = 1'b0;
        if (do_pop) void'(rx_mq.pop_front());
        if (rx_valid) begin
            if (n < 8 || do_pop) rx_mq.push_back(rx_data);
            else set_r = 1'b1;
        end
        if (UART_sel && MemWrite && addr == 4'h0) begin
            if (exp_q.size() < 8) exp_q.push_back(wdata[7:0]);
            else set_t = 1'b1;
        end
        clr      = UART_sel && MemWrite && (addr == 4'h8);
        m_tx_ovf = set_t || (m_tx_ovf && !(clr && wdata[4]));
        m_rx_ovr = set_r || (m_rx_ovr && !(clr && wdata[5]));
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            model_update();
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                             input logic rxv = 1'b0, input logic [7:0] rxd = 8'h00);
        UART_sel = 1'b1; MemWrite = 1'b1; addr = a; wdata = d;
        rx_valid = rxv; rx_data = rxd;
        tick(1);
        UART_sel = 1'b0; MemWrite = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input string tag,
                            input logic rxv = 1'b0, input logic [7:0] rxd = 8'h00);
        UART_sel = 1'b1; MemRead = 1'b1; addr = a;
        rx_valid = rxv; rx_data = rxd;
        @(negedge clk);
        check(tag, rdata, exp_rdata(a));
        tick(1);
        UART_sel = 1'b0; MemRead = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic check_irq(input string tag);
        check(tag, {31'b0, irq}, {31'b0, exp_irq()});
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_busy) && t < 2000) begin
            tick(1);
            t++;
        end
        if (t >= 2000) check(tag, exp_q.size(), 0);
        tick(8);
    endtask

    // transmitter model + scoreboard of transmitted bytes
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                pulse_cyc_q.push_back(cyc);
                if (exp_q.size() > 0) check("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
                else check("tx_spurious_start", {31'b0, tx_start}, 32'd0);
                busy_cnt = busy_len;
            end
            if (hold_busy) begin
                tx_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                tx_busy = 1'b1;
                busy_cnt--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        int t;
        int n;
        // reset state
        repeat (3) begin
            @(negedge clk);
            check("reset_tx_start", {31'b0, tx_start}, 32'd0);
            tick(1);
        end
        reset = 1'b0;
        check("reset_tx_data", {24'b0, tx_data}, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        bus_read(4'h8, "reset_status");

        // two bytes, 10-cycle busy frames
        busy_len = 10;
        pulse_cyc_q.delete();
        bus_write(4'h0, 32'h41);
        bus_write(4'h0, 32'h42);
        drain("tx2_drain");
        check("tx2_pulses", pulse_cyc_q.size(), 2);
        if (pulse_cyc_q.size() == 2)
            check("tx2_gap_ge12", {31'b0, (pulse_cyc_q[1] - pulse_cyc_q[0]) >= 12}, 32'd1);
        bus_read(4'h8, "tx2_status");

        // RX overflow, drain by reads, clear sticky
        for (int i = 0; i < 9; i++) rx_pulse(8'(8'h10 + i));
        bus_read(4'h8, "rx9_status");
        check_irq("rx9_irq");
        for (int i = 0; i < 9; i++) bus_read(4'h4, "rx_read");
        bus_write(4'h8, 32'h20);
        check_irq("rx_clr_irq");
        bus_read(4'h8, "rx_clr_status");

        // full RX: pop+push same cycle is no overrun; set beats clear
        for (int i = 0; i < 8; i++) rx_pulse(8'($urandom_range(0, 255)));
        bus_read(4'h4, "rx_full_poppush", 1'b1, 8'hE7);
        bus_read(4'h8, "rx_full_poppush_status");
        bus_write(4'h8, 32'h20, 1'b1, 8'h3C);
        bus_read(4'h8, "set_wins_status");
        bus_write(4'h8, 32'h20);
        for (int i = 0; i < 8; i++) bus_read(4'h4, "rx_full_read");
        check_irq("rx_full_irq");

        // fill TX while transmitter busy, overflow, concurrent RX read/push
        hold_busy = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) bus_write(4'h0, 32'h60 + i);
        bus_write(4'h0, 32'h99);
        bus_read(4'h8, "txfull_status");
        check_irq("txfull_irq");
        bus_read(4'h4, "rx_empty_poppush", 1'b1, 8'h55);
        bus_read(4'h8, "rx_count1_status");
        bus_write(4'h8, 32'h10);
        bus_read(4'h8, "tx_ovf_clr_status");
        busy_len = 2;
        hold_busy = 1'b0;
        drain("txfull_drain");
        bus_read(4'h4, "rx_55_read");
        bus_read(4'h8, "txfull_done_status");

        // reset while a frame is in WAIT_DONE
        for (int i = 0; i < 9; i++) rx_pulse(8'($urandom_range(0, 255)));
        busy_len = 20;
        bus_write(4'h0, 32'hA1);
        bus_write(4'h0, 32'hA2);
        bus_write(4'h0, 32'hA3);
        t = 0;
        while (exp_q.size() > 2 && t < 100) begin tick(1); t++; end
        if (t >= 100) check("rst_first_start_timeout", exp_q.size(), 2);
        tick(4);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_tx_start_during", {31'b0, tx_start}, 32'd0);
            tick(1);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_tx_start_after", {31'b0, tx_start}, 32'd0);
            tick(1);
        end
        bus_read(4'h8, "rst_status");
        check_irq("rst_irq");
        drain("rst_drain");

        // transmitter never raises busy: timeout path
        busy_len = 0;
        pulse_cyc_q.delete();
        bus_write(4'h0, 32'hC3);
        bus_write(4'h0, 32'hC4);
        drain("nobusy_drain");
        check("nobusy_pulses", pulse_cyc_q.size(), 2);
        if (pulse_cyc_q.size() == 2)
            check("nobusy_gap", pulse_cyc_q[1] - pulse_cyc_q[0], 6);
        bus_read(4'h8, "nobusy_status");

        // randomized register traffic with TX idle
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0: rx_pulse(8'($urandom_range(0, 255)));
                1: bus_read(4'h4, "rand_rxdata");
                2: bus_read(($urandom_range(0, 1) != 0) ? 4'h0 : 4'hC, "rand_zero_read");
                3: bus_write(($urandom_range(0, 1) != 0) ? 4'h4 : 4'hC, $urandom);
                4: begin
                    bus_read(4'h8, "rand_status");
                    check_irq("rand_irq");
                end
                default: bus_write(4'h8, $urandom);
            endcase
        end

        // randomized TX bursts with random busy lengths
        for (int k = 0; k < 5; k++) begin
            busy_len = $urandom_range(0, 12);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) bus_write(4'h0, $urandom);
            drain("rand_tx_drain");
            bus_read(4'h8, "rand_tx_status");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped UART controller between the processor datapath's load/store path and the byte-level UART transmitter/receiver cores. Buffers CPU writes in a TX FIFO and sequences the transmitter one byte at a time through a start/busy handshake. Captures received bytes into an RX FIFO for polled CPU reads. Exposes a sticky-error status register.

## Interface
- FIFO_DEPTH, 8: entries per FIFO; power of two, ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- UART_sel  in  1  CPU access targets the UART window this cycle.
- MemWrite  in  1  store strobe; qualified by UART_sel.
- MemRead  in  1  load strobe; qualified by UART_sel.
- addr  in  4  byte offset in window: 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS; 0xC reserved.
- wdata  in  32  store data; bits [7:0] are used for TXDATA.
- rdata  out  32  combinational load data for the current addr.
- tx_start  out  1  one-cycle pulse; transmitter latches tx_data.
- tx_data  out  8  byte presented with tx_start.
- tx_busy  in  1  transmitter is shifting a frame.
- rx_valid  in  1  one-cycle pulse; rx_data holds a received byte.
- rx_data  in  8  received byte.
- irq  out  1  level: RX FIFO non-empty OR any sticky error set.

## Operation
- All outputs reset to 0; FIFOs are emptied, sticky bits cleared, FSM to IDLE.
- TXDATA write (UART_sel & MemWrite & addr==0x0) pushes wdata[7:0]. If the FIFO is full, the byte is dropped and TX_OVF is set.
- RXDATA read (UART_sel & MemRead & addr==0x4):
  - rdata = {23'b0, 1'b1, head}, and the head is popped at the edge.
  - If the FIFO is empty, rdata = 0 and nothing is popped.
- STATUS read returns:
  - [0] tx_full, [1] tx_empty, [2] rx_nonempty, [3] rx_full
  - [4] TX_OVF, [5] RX_OVR, [6] tx_active (FSM≠IDLE)
  - [15:8] rx_count (zero-extended)
  - all other bits 0.
- STATUS write: writing 1 to bit 4 or bit 5 clears that sticky bit. Other bits are ignored.
- Reads of TXDATA or 0xC return 0. Writes to RXDATA or 0xC are ignored.
- rx_valid with the RX FIFO full: the byte is dropped and RX_OVR is set.
- Sticky bit set and clear in the same cycle: set wins.
- TX sequencing FSM:
  - IDLE: if TX FIFO non-empty and tx_busy==0, go to START.
  - START: drive tx_start=1 with tx_data=head; pop the head; go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy==1, then go to WAIT_DONE. Also returns to IDLE after 4 cycles without busy, so a transmitter with a zero-latency busy cannot lock the FSM.
  - WAIT_DONE: wait for tx_busy==0, then go to IDLE.
- tx_data holds its last value outside START.

## Timing
- Push and pop take effect at the edge. Status reflects them from the next cycle.
- rdata is combinational from the current registered state, so single-cycle loads work.
- Minimum FIFO-write-to-tx_start latency, with the FSM in IDLE and tx_busy low: write at edge N, START during cycle N+1, tx_start high in the cycle after edge N+1.
- Back-to-back bytes: at least 1 IDLE cycle between a frame's busy fall and the next tx_start.
- Simultaneous push and pop on the same FIFO:
  - Both occur and the count is unchanged.
  - On a full TX FIFO this is not an overflow.
  - On an empty RX FIFO, the read returns 0, the push succeeds, and the count becomes 1.
- Counts are $clog2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame returns the FSM to IDLE immediately. tx_start never pulses during or in the first cycle after reset. Any in-flight transmitter frame is not aborted by this block.

## Structure
- Package riscv_uart_pkg holds:
  - register offsets (UART_TXDATA, UART_RXDATA, UART_STATUS)
  - STATUS bit indices
  - FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE)
  - WAIT_BUSY timeout constant (4)
- Sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice (TX and RX).
  - Ports: clk, reset, push, pop, din, dout (first-word-fall-through), full, empty, count.
  - Push-when-full and pop-when-empty are ignored internally.

## Test plan
- Reset, then read STATUS -> 0x0000_0002 (tx_empty only); irq=0, tx_start=0.
- Write 0x41, 0x42; model the transmitter with busy high 10 cycles after start -> exactly two tx_start pulses carrying 0x41 then 0x42, separated by ≥12 cycles; STATUS bit1 returns to 1.
- Pulse rx_valid 9 times (0x10..0x18) with FIFO_DEPTH=8 -> STATUS[15:8]=8, bit5=1, irq=1. Eight RXDATA reads return 0x110..0x117; the ninth returns 0. Writing STATUS 0x20 clears bit5, then irq=0.
- Fill TX with tx_busy held high, then write a 9th byte -> TX_OVF=1, count stays 8. In the same cycle, RXDATA read on an empty FIFO plus rx_valid=0x55 -> rdata=0, rx_count=1.
- Assert reset during WAIT_DONE -> FSM IDLE, FIFOs empty, sticky bits 0, no tx_start for 2 cycles after release.
- tx_busy never asserts after tx_start -> FSM returns to IDLE after 4 WAIT_BUSY cycles and sends the next queued byte.
